// File: rtl/aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer
//
// Master sequencer for the AES-256 encryption core. It walks the round counter
// 0..NR and, inside each round, the step counter 0..STEPS-1. From these it
// derives the key-expansion round constant and the per-round control strobes.
// A block is started by a start handshake and is finished by a one-cycle done
// pulse. All outputs are registered.
//
// Optional feature macro: SEQ_STALL_EN
//   defined   : the stall port exists and freezes the sequence while high in RUN
//   undefined : no stall port; the sequence always runs to completion
//
// Ports
//   clk        in   1  global clock
//   reset      in   1  synchronous active-high reset, highest priority
//   start      in   1  begin a block (sampled only in IDLE)
//   abort      in   1  cancel the block in progress (RUN only)
//   stall      in   1  freeze the sequence (only with SEQ_STALL_EN)
//   busy       out  1  high while in RUN
//   done       out  1  one-cycle completion pulse
//   rnd_cnt    out  4  current round 0..NR
//   step       out  3  current step 0..STEPS-1
//   key_load   out  1  busy && round 0 && step 0
//   mix_en     out  1  busy && 0 < round < NR (MixColumns enable)
//   last_round out  1  busy && round == NR
//   rc         out  8  key-expansion round constant
// -----------------------------------------------------------------------------
module aes_round_sequencer #(
    parameter int NR    = 14,
    parameter int STEPS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
`ifdef SEQ_STALL_EN
    input  logic       stall,
`endif
    output logic       busy,
    output logic       done,
    output logic [3:0] rnd_cnt,
    output logic [2:0] step,
    output logic       key_load,
    output logic       mix_en,
    output logic       last_round,
    output logic [7:0] rc
);

    localparam logic [3:0] LAST_RND  = 4'(NR);
    localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [3:0] rnd_s;
    logic [2:0] step_s;
    logic [7:0] rc_s;
    logic       stall_s;

`ifdef SEQ_STALL_EN
    assign stall_s = stall;
`else
    assign stall_s = 1'b0;
`endif

    // Round constant after advancing into round r: 01 entering round 1,
    // doubled entering every later odd round, held otherwise.
    function automatic logic [7:0] next_rc(input logic [3:0] r, input logic [7:0] cur);
        logic [7:0] res;
        if (r[0] == 1'b0) begin
            res = cur;
        end else if (r == 4'd1) begin
            res = 8'h01;
        end else begin
            res = {cur[6:0], 1'b0};
        end
        return res;
    endfunction

    // Next-state and next-counter computation for the sequencer.
    always_comb begin
        state_s = state_r;
        rnd_s   = rnd_cnt;
        step_s  = step;
        rc_s    = rc;
        case (state_r)
            IDLE: begin
                // start wins over abort here; abort has no meaning in IDLE
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
                rnd_s  = 4'd0;
                step_s = 3'd0;
                rc_s   = 8'h00;
            end
            RUN: begin
                if (abort) begin
                    state_s = IDLE;
                    rnd_s   = 4'd0;
                    step_s  = 3'd0;
                    rc_s    = 8'h00;
                end else if (stall_s) begin
                    state_s = RUN;
                end else if ((rnd_cnt == LAST_RND) && (step == LAST_STEP)) begin
                    // counters hold their final values while done is shown
                    state_s = DONE;
                end else if (step < LAST_STEP) begin
                    step_s = step + 3'd1;
                end else begin
                    step_s = 3'd0;
                    rnd_s  = rnd_cnt + 4'd1;
                    rc_s   = next_rc(rnd_cnt + 4'd1, rc);
                end
            end
            DONE: begin
                state_s = IDLE;
                rnd_s   = 4'd0;
                step_s  = 3'd0;
                rc_s    = 8'h00;
            end
            default: begin
                state_s = IDLE;
                rnd_s   = 4'd0;
                step_s  = 3'd0;
                rc_s    = 8'h00;
            end
        endcase
    end

    // State, counter and decoded-strobe registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            rnd_cnt    <= 4'd0;
            step       <= 3'd0;
            rc         <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            key_load   <= 1'b0;
            mix_en     <= 1'b0;
            last_round <= 1'b0;
        end else begin
            state_r    <= state_s;
            rnd_cnt    <= rnd_s;
            step       <= step_s;
            rc         <= rc_s;
            busy       <= (state_s == RUN);
            done       <= (state_s == DONE);
            key_load   <= (state_s == RUN) && (rnd_s == 4'd0) && (step_s == 3'd0);
            mix_en     <= (state_s == RUN) && (rnd_s != 4'd0) && (rnd_s < LAST_RND);
            last_round <= (state_s == RUN) && (rnd_s == LAST_RND);
        end
    end

endmodule
